plazer_master_0_timing_fifo_adt: RTL and testbench

PLAZER_MASTER_0_TIMING_FIFO_ADT -- requirements
Module: plazer_master_0_timing_fifo_adt

---
 rtl/plazer_timing_adt_pkg.sv | 11 +
 rtl/plazer_timing_adt_ptr.sv | 48 ++++
 rtl/plazer_master_0_timing_fifo_adt.sv | 86 ++++++++
 tb/tb_plazer_master_0_timing_fifo_adt.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/plazer_timing_adt_pkg.sv
// Shared defaults for the plazer timing FIFO: payload width, depth and the
// dropped-beat counter width used when PLAZER_TIMING_ADT_OVF_CNT_EN is defined.
package plazer_timing_adt_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned OVF_CNT_W  = 16;

  typedef logic [OVF_CNT_W-1:0] ovf_cnt_t;

endpackage

// File: rtl/plazer_timing_adt_ptr.sv
// Write/read pointer pair for the timing FIFO; pointers carry one extra wrap
// bit so full and empty are distinguishable and level is a plain subtraction.
module plazer_timing_adt_ptr
  import plazer_timing_adt_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_wr_req,
  input  logic          i_rd_req,
  output logic          o_wr_en,
  output logic          o_rd_en,
  output logic          o_drop,
  output logic          o_empty,
  output logic [AW-1:0] o_waddr,
  output logic [AW-1:0] o_raddr,
  output logic [AW:0]   o_level
);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_full;

  always_comb begin
    o_empty = (r_wptr == r_rptr);
    w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    o_rd_en = i_rd_req && !o_empty;
    // A read in the same cycle frees the slot, so a full buffer still accepts.
    o_wr_en = i_wr_req && (!w_full || o_rd_en);
    o_drop  = i_wr_req && w_full && !o_rd_en;
    o_waddr = r_wptr[AW-1:0];
    o_raddr = r_rptr[AW-1:0];
    o_level = r_wptr - r_rptr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (o_wr_en) r_wptr <= r_wptr + 1'b1;
      if (o_rd_en) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/plazer_master_0_timing_fifo_adt.sv
// Non-backpressurable ingress FIFO with sticky overflow flag. Defining
// PLAZER_TIMING_ADT_OVF_CNT_EN adds a saturating dropped-beat counter output.
module plazer_master_0_timing_fifo_adt
  import plazer_timing_adt_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              overflow,
  output logic [AW:0]       level
`ifdef PLAZER_TIMING_ADT_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0] ovf_count
`endif
);

  logic              w_wr_en;
  logic              w_rd_en;
  logic              w_drop;
  logic              w_empty;
  logic [AW-1:0]     w_waddr;
  logic [AW-1:0]     w_raddr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_overflow;

  plazer_timing_adt_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk      (clk),
    .reset    (reset),
    .i_wr_req (in_valid),
    .i_rd_req (out_ready),
    .o_wr_en  (w_wr_en),
    .o_rd_en  (w_rd_en),
    .o_drop   (w_drop),
    .o_empty  (w_empty),
    .o_waddr  (w_waddr),
    .o_raddr  (w_raddr),
    .o_level  (level)
  );

  // Storage is deliberately not reset; pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_waddr] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  always_comb begin
    out_valid = !w_empty;
    out_data  = r_mem[w_raddr];
    overflow  = r_overflow;
  end

`ifdef PLAZER_TIMING_ADT_OVF_CNT_EN
  ovf_cnt_t r_ovf_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         r_ovf_count <= '0;
    else if (w_drop && r_ovf_count != '1) r_ovf_count <= r_ovf_count + 1'b1;
  end

  assign ovf_count = r_ovf_count;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && w_drop) $display("%m: beat 0x%0h dropped at %0t", in_data, $time);
  end
`endif

  logic w_unused;
  assign w_unused = w_rd_en;

endmodule

// File: tb/tb_plazer_master_0_timing_fifo_adt.sv
// Directed bench for plazer_master_0_timing_fifo_adt (DATA_W=8, DEPTH=4);
// ovf_count checks follow PLAZER_TIMING_ADT_OVF_CNT_EN.
module tb_plazer_master_0_timing_fifo_adt;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       overflow;
  logic [2:0] level;
`ifdef PLAZER_TIMING_ADT_OVF_CNT_EN
  logic [15:0] ovf_count;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  plazer_master_0_timing_fifo_adt #(
    .DATA_W (8),
    .DEPTH  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .overflow  (overflow),
    .level     (level)
`ifdef PLAZER_TIMING_ADT_OVF_CNT_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic fill4();
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(i);
      cyc();
    end
    in_valid = 1'b0;
  endtask

  logic [7:0] q[$];
  int unsigned drops;
  int unsigned guard;

  initial begin
    in_data = '0;
    do_reset();
    check_vec("rst_valid", 32'(out_valid), 0);
    check_vec("rst_level", 32'(level), 0);
    check_vec("rst_ovf", 32'(overflow), 0);

    // passthrough
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    check_vec("pt_empty_valid", 32'(out_valid), 0);
    cyc();
    check_vec("pt_d0", 32'(out_data), 32'h11);
    check_vec("pt_l0", 32'(level), 1);
    in_data = 8'h22;
    cyc();
    check_vec("pt_d1", 32'(out_data), 32'h22);
    check_vec("pt_l1", 32'(level), 1);
    in_data = 8'h33;
    cyc();
    check_vec("pt_d2", 32'(out_data), 32'h33);
    check_vec("pt_v2", 32'(out_valid), 1);
    in_valid = 1'b0;
    cyc();
    check_vec("pt_lend", 32'(level), 0);
    check_vec("pt_vend", 32'(out_valid), 0);
    check_vec("pt_ovf", 32'(overflow), 0);

    // fill and hold, then drain
    fill4();
    check_vec("fill_level", 32'(level), 4);
    check_vec("fill_head", 32'(out_data), 32'hA0);
    cyc();
    check_vec("fill_hold", 32'(out_data), 32'hA0);
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      check_vec("fill_drain", 32'(out_data), 32'hA0 + i);
      cyc();
    end
    check_vec("fill_empty", 32'(level), 0);
    check_vec("fill_nvalid", 32'(out_valid), 0);

    // full with simultaneous read and write
    fill4();
    in_valid  = 1'b1;
    in_data   = 8'h55;
    out_ready = 1'b1;
    check_vec("frw_head", 32'(out_data), 32'hA0);
    cyc();
    in_valid = 1'b0;
    check_vec("frw_level", 32'(level), 4);
    check_vec("frw_ovf", 32'(overflow), 0);
    for (int unsigned i = 1; i < 4; i++) begin
      check_vec("frw_drain", 32'(out_data), 32'hA0 + i);
      cyc();
    end
    check_vec("frw_last", 32'(out_data), 32'h55);
    cyc();
    check_vec("frw_empty", 32'(level), 0);

    // overflow
    fill4();
    in_valid = 1'b1;
    in_data  = 8'hFF;
    cyc();
    in_valid = 1'b0;
    check_vec("ovf_flag", 32'(overflow), 1);
    check_vec("ovf_level", 32'(level), 4);
`ifdef PLAZER_TIMING_ADT_OVF_CNT_EN
    check_vec("ovf_cnt1", 32'(ovf_count), 1);
`endif
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      check_vec("ovf_drain", 32'(out_data), 32'hA0 + i);
      cyc();
    end
    check_vec("ovf_gone", 32'(out_valid), 0);
    check_vec("ovf_sticky", 32'(overflow), 1);

    // wrap with random ready duty against a queue model
    do_reset();
    check_vec("wrap_rst_ovf", 32'(overflow), 0);
    drops = 0;
    for (int unsigned i = 0; i < 40; i++) begin
      in_valid  = 1'b1;
      in_data   = 8'(8'h30 + i);
      out_ready = (i < 6) ? 1'b0 : 1'($urandom_range(0, 1));
      check_vec("wrap_level", 32'(level), q.size());
      check_vec("wrap_valid", 32'(out_valid), (q.size() > 0) ? 1 : 0);
      if (out_ready && q.size() > 0) begin
        check_vec("wrap_data", 32'(out_data), 32'(q[0]));
        void'(q.pop_front());
      end
      if (q.size() < 4) q.push_back(in_data);
      else drops++;
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      check_vec("wrap_tail", 32'(out_data), 32'(q[0]));
      void'(q.pop_front());
      cyc();
      guard++;
    end
    check_vec("wrap_drained", 32'(level), 0);
    check_vec("wrap_ovf", 32'(overflow), (drops > 0) ? 1 : 0);
`ifdef PLAZER_TIMING_ADT_OVF_CNT_EN
    check_vec("wrap_ovf_cnt", 32'(ovf_count), drops);
`endif

    // reset mid-operation, asserted between clock edges
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hC0 + 8'(i);
      cyc();
    end
    in_valid = 1'b0;
    check_vec("mid_level3", 32'(level), 3);
    #2;
    reset = 1'b1;
    #1;
    check_vec("mid_valid", 32'(out_valid), 0);
    check_vec("mid_level", 32'(level), 0);
    check_vec("mid_ovf", 32'(overflow), 0);
`ifdef PLAZER_TIMING_ADT_OVF_CNT_EN
    check_vec("mid_ovf_cnt", 32'(ovf_count), 0);
`endif
    #3;
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h77;
    cyc();
    in_valid = 1'b0;
    check_vec("mid_l1", 32'(level), 1);
    check_vec("mid_d77", 32'(out_data), 32'h77);
    out_ready = 1'b1;
    cyc();
    check_vec("mid_alone", 32'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
